logic_tile_config_loader: RTL
=============================

// Module: logic_tile_config_loader
// PURPOSE
//   Parametrised loader for logic-tile configuration shift chains. Accepts config words over a
//   valid/ready stream, serialises them into CHAINS parallel chains (one bit per chain per shift),
//   and returns the bits shifted out of the chain tails as a readback word stream.
//   Sits between the bitstream source and one or more logic-tile config chains.
// PARAMETERS
//   CHAINS        2    number of parallel config chains driven in lockstep
//   CHAIN_LENGTH  146  bits per chain = shift cycles per load
//   WORD_WIDTH    32   stream word width; must be a multiple of CHAINS (elaboration error otherwise)
// PORTS
//   clock         in   1             single clock
//   reset         in   1             synchronous, active-high
//   start         in   1             pulse: begin a load (ignored while busy)
//   busy          out  1             high from the cycle after start until done
//   done          out  1             one-cycle pulse when load and readback fully complete
//   wr_data       in   WORD_WIDTH    config word; bit k*CHAINS+c -> chain c, shift k
//   wr_valid      in   1
//   wr_ready      out  1
//   rd_data       out  WORD_WIDTH    readback word, same bit packing as wr_data
//   rd_valid      out  1
//   rd_ready      in   1
//   cfg_enable    out  1             chain shift enable
//   cfg_data_in   out  CHAINS        head bits into chains
//   cfg_data_out  in   CHAINS        tail bits from chains
// BEHAVIOUR
//   - SLICES = WORD_WIDTH/CHAINS; WORDS = ceil(CHAIN_LENGTH/SLICES); last word uses
//     CHAIN_LENGTH - (WORDS-1)*SLICES slices, its upper wr_data bits are discarded.
//   - Reset: state IDLE; busy, done, wr_ready, rd_valid, cfg_enable = 0; rd_data, counters = 0.
//   - IDLE: start=1 -> LOAD next cycle, busy=1, shift counter=0, word counter=0.
//   - LOAD: wr_ready = !rd_valid | rd_ready. On wr_valid&wr_ready latch word -> SHIFT.
//   - SHIFT: one slice per cycle; cfg_enable=1; cfg_data_in = low CHAINS bits of word register;
//     cfg_data_out sampled same cycle (pre-shift tail) into capture reg at slice position; word >>= CHAINS.
//     Last slice of word: capture (zero-filled above used slices) -> rd_data, rd_valid=1;
//     then LOAD, or FLUSH if word counter = WORDS-1.
//   - FLUSH: wait rd_valid=0 -> DONE. DONE: done=1 one cycle, busy=0 -> IDLE.
//   - rd_valid holds rd_data stable until rd_ready; clears the cycle after acceptance.
//   - cfg_enable is 0 in every state but SHIFT; gaps in wr_valid or rd_ready stall, never drop bits.
//   - Exactly CHAIN_LENGTH cfg_enable cycles per load; first bit shifted lands at chain position
//     CHAIN_LENGTH-1. Readback of the previous load equals the previous wr_data words (masked).
//   - start while busy: ignored. Reset mid-operation: next cycle all outputs at reset values;
//     chain contents are left partially shifted; a fresh start restarts from slice 0.
//   - Min latency: start -> wr_ready 1 cycle; word accept -> first cfg_enable 1 cycle.
// STRUCTURE
//   - Package kfpga_config_pkg: loader state enum (IDLE, LOAD, SHIFT, FLUSH, DONE), functions
//     for SLICES, WORDS, last-word slice count, counter widths ($clog2).
//   - One sub-module: config_word_serializer (word register + slice counter + capture register).
// TESTING  (bench models chains as CHAINS behavioural shift registers; CHAINS=2, CHAIN_LENGTH=10,
//           WORD_WIDTH=8 -> SLICES=4, WORDS=3, last word 2 slices)
//   1. Zeroed chains, start, words 0xA5,0x3C,0x0F -> 10 cfg_enable cycles, rd_data 0x00 x3, one done pulse.
//   2. Second load 0xFF,0xFF,0xFF -> rd_data 0xA5,0x3C,0x0F; chain models all ones; last rd upper nibble 0.
//   3. wr_valid low 5 cycles between words -> cfg_enable 0 during gap, readback still exact.
//   4. rd_ready low 7 cycles after first rd_valid -> wr_ready 0, cfg_enable 0, rd_data stable; resumes clean.
//   5. reset after 3 shifts -> next cycle busy=0, cfg_enable=0, rd_valid=0, wr_ready=0; restart loads correctly.
//   6. start pulsed while busy -> ignored, shift count still 10; CHAIN_LENGTH=8 variant -> WORDS=2, full last word.

Source files
------------

// File: rtl/logic_tile_config_loader_pkg.sv
// Shared types and sizing helpers for the logic-tile configuration loader.
package kfpga_config_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FLUSH, DONE} loader_state_t;

  function automatic int slices_of(input int word_width, input int chains);
    return word_width / chains;
  endfunction

  function automatic int words_of(input int chain_length, input int word_width, input int chains);
    return (chain_length + slices_of(word_width, chains) - 1) / slices_of(word_width, chains);
  endfunction

  function automatic int last_slices_of(input int chain_length, input int word_width, input int chains);
    return chain_length - (words_of(chain_length, word_width, chains) - 1) * slices_of(word_width, chains);
  endfunction

  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/config_word_serializer.sv
// Word register, slice counter and readback capture for one config word.
module config_word_serializer
  import kfpga_config_pkg::*;
#(
  parameter int CHAINS      = 2,
  parameter int WORD_WIDTH  = 32,
  parameter int SLICES      = 16,
  parameter int LAST_SLICES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  last_word,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic [CHAINS-1:0]     tail,
  output logic [CHAINS-1:0]     head,
  output logic                  slice_end,
  output logic [WORD_WIDTH-1:0] captured
);

  localparam int SCW = count_width(SLICES);
  localparam logic [SCW-1:0] FULL_END = SCW'(SLICES - 1);
  localparam logic [SCW-1:0] LAST_END = SCW'(LAST_SLICES - 1);

  logic [WORD_WIDTH-1:0] word_reg;
  logic [WORD_WIDTH-1:0] capture;
  logic [SCW-1:0]        slice_cnt;

  assign head      = word_reg[CHAINS-1:0];
  assign slice_end = (slice_cnt == (last_word ? LAST_END : FULL_END));

  // Capture is cleared on load, so slices beyond the last used one read back as zero.
  always_comb begin
    captured = capture;
    for (int s = 0; s < SLICES; s++)
      if (slice_cnt == SCW'(s)) captured[s*CHAINS +: CHAINS] = tail;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_reg  <= '0;
      capture   <= '0;
      slice_cnt <= '0;
    end else if (load) begin
      word_reg  <= data;
      capture   <= '0;
      slice_cnt <= '0;
    end else if (shift) begin
      word_reg  <= word_reg >> CHAINS;
      capture   <= captured;
      slice_cnt <= slice_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/logic_tile_config_loader.sv
// Streams config words into parallel logic-tile shift chains and returns the
// displaced chain contents as a readback word stream.
module logic_tile_config_loader
  import kfpga_config_pkg::*;
#(
  parameter int CHAINS       = 2,
  parameter int CHAIN_LENGTH = 146,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  cfg_enable,
  output logic [CHAINS-1:0]     cfg_data_in,
  input  logic [CHAINS-1:0]     cfg_data_out
);

  localparam int SLICES      = slices_of(WORD_WIDTH, CHAINS);
  localparam int WORDS       = words_of(CHAIN_LENGTH, WORD_WIDTH, CHAINS);
  localparam int LAST_SLICES = last_slices_of(CHAIN_LENGTH, WORD_WIDTH, CHAINS);
  localparam int WCW         = count_width(WORDS);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);

  if (WORD_WIDTH % CHAINS != 0) begin : g_width_check
    $error("WORD_WIDTH must be a multiple of CHAINS");
  end

  loader_state_t         state, state_next;
  logic [WCW-1:0]        word_cnt;
  logic                  last_word;
  logic                  load;
  logic                  slice_end;
  logic [WORD_WIDTH-1:0] captured;

  assign last_word = (word_cnt == LAST_WORD);
  assign load      = wr_valid && wr_ready;

  config_word_serializer #(
    .CHAINS      (CHAINS),
    .WORD_WIDTH  (WORD_WIDTH),
    .SLICES      (SLICES),
    .LAST_SLICES (LAST_SLICES)
  ) u_serializer (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .shift     (cfg_enable),
    .last_word (last_word),
    .data      (wr_data),
    .tail      (cfg_data_out),
    .head      (cfg_data_in),
    .slice_end (slice_end),
    .captured  (captured)
  );

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    wr_ready   = 1'b0;
    cfg_enable = 1'b0;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        busy = 1'b1;
        // A new word may only start once the previous readback slot is free.
        wr_ready = !rd_valid || rd_ready;
        if (wr_valid && wr_ready) state_next = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        cfg_enable = 1'b1;
        if (slice_end) state_next = last_word ? FLUSH : LOAD;
      end
      FLUSH: begin
        busy = 1'b1;
        if (!rd_valid) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      word_cnt <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start)    word_cnt <= '0;
      else if (cfg_enable && slice_end) word_cnt <= word_cnt + 1'b1;
      if (cfg_enable && slice_end) begin
        rd_data  <= captured;
        rd_valid <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule
